// File: rtl/mem_pwr_pkg.sv
// Shared types and helpers for the power-aware single-port memory.
// Parity storage in mem_pwr_sp is enabled by defining MEM_PWR_PARITY_EN.
package mem_pwr_pkg;

  typedef enum logic [1:0] {
    PWRUP    = 2'd0,
    READY    = 2'd1,
    BROWNOUT = 2'd2
  } state_e;

  localparam logic [1:0] ERR_OK     = 2'b00;
  localparam logic [1:0] ERR_COLL   = 2'b01;
  localparam logic [1:0] ERR_RANGE  = 2'b10;
  localparam logic [1:0] ERR_UNINIT = 2'b11;

  // Even parity over a zero-extended word; zero extension leaves parity unchanged.
  function automatic logic even_par(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/mem_pwr_rdpipe.sv
// Read-result shift pipeline: STAGES registers of {valid, data, uninit}.
// flush drops every in-flight entry on the next edge.
module mem_pwr_rdpipe
  import mem_pwr_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_uninit,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_data,
  output logic              out_uninit
);

  logic              vld_q    [STAGES];
  logic              vld_d    [STAGES];
  logic [DATA_W-1:0] data_q   [STAGES];
  logic [DATA_W-1:0] data_d   [STAGES];
  logic              uninit_q [STAGES];
  logic              uninit_d [STAGES];

  always_comb begin
    vld_d[0]    = in_vld & ~flush;
    data_d[0]   = in_data;
    uninit_d[0] = in_uninit;
    for (int i = 1; i < STAGES; i++) begin
      vld_d[i]    = vld_q[i-1] & ~flush;
      data_d[i]   = data_q[i-1];
      uninit_d[i] = uninit_q[i-1];
    end
  end

  // Stage registers: only the valid bits carry reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) vld_q[i] <= 1'b0;
    end else begin
      vld_q <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    data_q   <= data_d;
    uninit_q <= uninit_d;
  end

  assign out_vld    = vld_q[STAGES-1];
  assign out_data   = data_q[STAGES-1];
  assign out_uninit = uninit_q[STAGES-1];

endmodule

// File: rtl/mem_pwr_sp.sv
// Single-port memory with supply-good FSM, per-word valid bits and RD_LAT read pipe.
// Define MEM_PWR_PARITY_EN to store and check one even-parity bit per word.
module mem_pwr_sp
  import mem_pwr_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4096,
  parameter int RD_LAT    = 1,
  parameter int PWRUP_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] add,
  input  logic [DATA_W-1:0] din,
  input  logic              pwr_ok,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic              rdy,
  output logic              brownout,
  output logic [1:0]        err
);

  localparam int              CNT_W    = (PWRUP_CYC > 1) ? $clog2(PWRUP_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PWRUP_CYC - 1);
  localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              brown_q, brown_d;
  logic [1:0]        err_q, err_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_vld_q, dout_vld_d;
  logic [DEPTH-1:0]  valid_q, valid_d;

  logic              ready, bo_evt, acc, coll, in_range, wr_acc, rd_acc, flush;
  logic [DATA_W-1:0] rd_word;
  logic              rd_uninit;
  logic              pipe_vld, pipe_uninit;
  logic [DATA_W-1:0] pipe_data;

  // A supply drop outranks any access presented on the same edge.
  assign ready    = (state_q == READY);
  assign bo_evt   = ready & ~pwr_ok;
  assign acc      = ready & pwr_ok & ~cen & (rd | wr);
  assign coll     = rd & wr;
  assign in_range = {1'b0, add} < DEPTH_L;
  assign wr_acc   = acc & wr & ~rd & in_range;
  assign rd_acc   = acc & rd & ~wr & in_range;
  assign flush    = cen | bo_evt;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[add] <= din;
  end

  assign rd_word = mem_q[add];

`ifdef MEM_PWR_PARITY_EN
  logic par_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_acc) par_q[add] <= even_par(64'(din));
  end

  // A parity mismatch is reported exactly like an unwritten word.
  assign rd_uninit = ~valid_q[add] | (par_q[add] != even_par(64'(rd_word)));
`else
  assign rd_uninit = ~valid_q[add];
`endif

  mem_pwr_rdpipe #(
    .DATA_W (DATA_W),
    .STAGES (RD_LAT)
  ) u_rdpipe (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_vld     (rd_acc),
    .in_data    (rd_word),
    .in_uninit  (rd_uninit),
    .out_vld    (pipe_vld),
    .out_data   (pipe_data),
    .out_uninit (pipe_uninit)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    brown_d    = brown_q;
    valid_d    = valid_q;
    err_d      = err_q;
    dout_d     = dout_q;
    dout_vld_d = 1'b0;

    unique case (state_q)
      PWRUP, BROWNOUT: begin
        if (!pwr_ok) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      READY: begin
        if (!pwr_ok) begin
          state_d = BROWNOUT;
          cnt_d   = '0;
          brown_d = 1'b1;
          valid_d = '0;
        end
      end
      default: state_d = PWRUP;
    endcase

    if (cen) begin
      dout_d = '0;
    end else if (pipe_vld && !bo_evt) begin
      dout_vld_d = 1'b1;
      dout_d     = pipe_uninit ? '0 : pipe_data;
      err_d      = pipe_uninit ? ERR_UNINIT : ERR_OK;
    end

    // Status of an access accepted this edge overrides a read completing on it.
    if (acc) begin
      brown_d = 1'b0;
      if (coll) begin
        err_d = ERR_COLL;
      end else if (!in_range) begin
        err_d = ERR_RANGE;
      end else if (wr) begin
        err_d        = ERR_OK;
        valid_d[add] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= PWRUP;
      cnt_q      <= '0;
      brown_q    <= 1'b0;
      err_q      <= ERR_OK;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      brown_q    <= brown_d;
      err_q      <= err_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      valid_q    <= valid_d;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign rdy      = ready;
  assign brownout = brown_q;
  assign err      = err_q;

endmodule
